// File: rtl/ibex_pkg.sv
// ibex_pkg: shared types for the EX-to-WB skid buffer.
package ibex_pkg;

    typedef enum logic [1:0] {
        EX_WB_EMPTY,
        EX_WB_ONE,
        EX_WB_FULL
    } ex_wb_state_e;

    typedef struct packed {
        logic [31:0] wdata;
        logic [4:0]  waddr;
        logic        we;
        logic [31:0] pc;
    } ex_wb_entry_t;

    function automatic logic fwd_match(ex_wb_entry_t e, logic v, logic [4:0] rs);
        return v & e.we & (e.waddr == rs) & (rs != 5'd0);
    endfunction

endpackage

// File: rtl/ibex_ex_wb_pipe.sv
// ibex_ex_wb_pipe: 2-entry in-order EX-to-WB skid buffer with operand forwarding from held entries.
module ibex_ex_wb_pipe
    import ibex_pkg::*;
#(
    parameter bit ResetAll = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        ex_valid_i,
    output logic        ex_ready_o,
    input  logic [31:0] ex_result_i,
    input  logic [4:0]  ex_rf_waddr_i,
    input  logic        ex_rf_we_i,
    input  logic [31:0] ex_pc_i,
    input  logic        flush_i,
    output logic        wb_valid_o,
    input  logic        wb_ready_i,
    output logic [31:0] wb_rf_wdata_o,
    output logic [4:0]  wb_rf_waddr_o,
    output logic        wb_rf_we_o,
    output logic [31:0] wb_pc_o,
    input  logic [4:0]  id_rs1_addr_i,
    input  logic [4:0]  id_rs2_addr_i,
    output logic        fwd_rs1_hit_o,
    output logic        fwd_rs2_hit_o,
    output logic [31:0] fwd_rs1_data_o,
    output logic [31:0] fwd_rs2_data_o
);

    ex_wb_state_e state_q, state_d;
    logic         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    ex_wb_entry_t mem_q [2];
    ex_wb_entry_t mem_d [2];
    ex_wb_entry_t old_e, young_e;
    logic         accept, pop, young_v;
    logic         h1_y, h1_o, h2_y, h2_o;

    assign ex_ready_o = state_q != EX_WB_FULL;
    assign wb_valid_o = state_q != EX_WB_EMPTY;
    assign accept     = ex_valid_i & ex_ready_o;
    assign pop        = wb_valid_o & wb_ready_i;

    always_comb begin
        state_d  = flush_i ? EX_WB_EMPTY :
                   (accept & ~pop) ? (state_q == EX_WB_EMPTY ? EX_WB_ONE : EX_WB_FULL) :
                   (pop & ~accept) ? (state_q == EX_WB_FULL ? EX_WB_ONE : EX_WB_EMPTY) :
                   state_q;
        wr_ptr_d = flush_i ? 1'b0 : wr_ptr_q ^ accept;
        rd_ptr_d = flush_i ? 1'b0 : rd_ptr_q ^ pop;
        mem_d    = mem_q;
        if (accept && !flush_i) begin
            mem_d[wr_ptr_q] = '{wdata: ex_result_i, waddr: ex_rf_waddr_i,
                                we: ex_rf_we_i & (ex_rf_waddr_i != 5'd0), pc: ex_pc_i};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= EX_WB_EMPTY;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    if (ResetAll) begin : g_payload_rst
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int i = 0; i < 2; i++) mem_q[i] <= '0;
            end else begin
                mem_q <= mem_d;
            end
        end
    end else begin : g_payload
        always_ff @(posedge clk_i) begin
            mem_q <= mem_d;
        end
    end

    assign wb_rf_wdata_o = mem_q[rd_ptr_q].wdata;
    assign wb_rf_waddr_o = mem_q[rd_ptr_q].waddr;
    assign wb_rf_we_o    = wb_valid_o & mem_q[rd_ptr_q].we;
    assign wb_pc_o       = mem_q[rd_ptr_q].pc;

    // Only the head is valid in ONE; the non-head slot holds the younger entry in FULL.
    assign old_e   = mem_q[rd_ptr_q];
    assign young_e = mem_q[~rd_ptr_q];
    assign young_v = state_q == EX_WB_FULL;

    assign h1_y = fwd_match(young_e, young_v, id_rs1_addr_i);
    assign h1_o = fwd_match(old_e, wb_valid_o, id_rs1_addr_i);
    assign h2_y = fwd_match(young_e, young_v, id_rs2_addr_i);
    assign h2_o = fwd_match(old_e, wb_valid_o, id_rs2_addr_i);

    assign fwd_rs1_hit_o  = h1_y | h1_o;
    assign fwd_rs2_hit_o  = h2_y | h2_o;
    assign fwd_rs1_data_o = h1_y ? young_e.wdata : old_e.wdata;
    assign fwd_rs2_data_o = h2_y ? young_e.wdata : old_e.wdata;

endmodule
